// File: rtl/ws_cart_unlock_rx_pkg.sv
// Shared constants and types for the Bandai 2003 cartridge unlock handshake.
// The mapper RTL and the mapper model in the bench use these too.
package ws_cart_unlock_rx_pkg;

   localparam int unsigned ADDR_W     = 8;
   localparam int unsigned DATA_BITS  = 16;
   localparam int unsigned FRAME_BITS = 18;
   localparam int unsigned ERR_W      = 2;

   localparam logic [ADDR_W-1:0] ADDR_ACK = 8'h5A;
   localparam logic [ADDR_W-1:0] ADDR_NAK = 8'hA5;

   typedef enum logic [ERR_W-1:0] {
      ERR_NONE    = 2'b00,
      ERR_TIMEOUT = 2'b01,
      ERR_FRAMING = 2'b10,
      ERR_PAYLOAD = 2'b11
   } err_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ACK  = 3'd1,
      ST_NAK  = 3'd2,
      ST_HUNT = 3'd3,
      ST_DATA = 3'd4,
      ST_STOP = 3'd5,
      ST_DONE = 3'd6
   } state_e;

   // Result of one unlock attempt, frozen on entry to DONE.
   typedef struct packed {
      logic                 done;
      logic                 ok;
      err_e                 err;
      logic [DATA_BITS-1:0] payload;
   } status_t;

endpackage

// File: rtl/ws_cart_unlock_rx_if.sv
// Cartridge-side unlock bus: address byte out, SO frame in, plus status.
interface ws_cart_unlock_rx_if;
   import ws_cart_unlock_rx_pkg::*;

   logic                 start;
   logic                 SO;
   logic [ADDR_W-1:0]    ADDR;
   logic                 busy;
   logic                 done;
   logic                 ok;
   logic [ERR_W-1:0]     err;
   logic [DATA_BITS-1:0] payload;
   logic                 sys_ctrl1_b7;

   modport master (
      input  start, SO,
      output ADDR, busy, done, ok, err, payload, sys_ctrl1_b7
   );

   modport slave (
      output start, SO,
      input  ADDR, busy, done, ok, err, payload, sys_ctrl1_b7
   );

endinterface

// File: rtl/ws_sync_bit.sv
// Single-bit synchronizer of configurable depth; flops reset to 1 (SO idle level).
module ws_sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   if (STAGES == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk & rst_n;
      assign q_o            = d_i;
   end else begin : g_chain
      logic [STAGES-1:0] sync_q;
      logic [STAGES:0]   shift_w;

      assign shift_w = {sync_q, d_i};

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_q <= '1;
         end else begin
            sync_q <= shift_w[STAGES-1:0];
         end
      end

      assign q_o = sync_q[STAGES-1];
   end

endmodule

// File: rtl/ws_cart_unlock_rx.sv
// Console-side unlock sequencer: issues ADDR 5A/A5, then receives and checks
// the 18-bit SO frame; a matching payload authenticates the cart.
module ws_cart_unlock_rx
   import ws_cart_unlock_rx_pkg::*;
#(
   parameter logic [DATA_BITS-1:0] EXPECTED    = 16'h28A0,
   parameter int unsigned          TIMEOUT     = 8,
   parameter int unsigned          SYNC_STAGES = 2,
   parameter logic [ADDR_W-1:0]    IDLE_ADDR   = 8'h00,
   parameter bit                   AUTO_START  = 1'b1
) (
   input  logic              CLK,
   input  logic              RSTn,
   ws_cart_unlock_rx_if.master bus
);

   // Hunt window is widened by the synchronizer delay so the budget stays in SO time.
   localparam int unsigned WAIT_MAX = TIMEOUT + SYNC_STAGES;
   localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 2);
   localparam int unsigned BIT_W    = $clog2(DATA_BITS);

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    addr_q,  addr_d;
   logic                 busy_q,  busy_d;
   logic                 auto_q,  auto_d;
   logic [WAIT_W-1:0]    wait_q,  wait_d;
   logic [BIT_W-1:0]     bit_q,   bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   status_t              stat_q,  stat_d;
   logic                 so_s;

   ws_sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_so_sync (
      .clk   (CLK),
      .rst_n (RSTn),
      .d_i   (bus.SO),
      .q_o   (so_s)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      busy_d  = busy_q;
      auto_d  = auto_q;
      wait_d  = wait_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      stat_d  = stat_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start || auto_q) begin
               state_d = ST_ACK;
               addr_d  = ADDR_ACK;
               busy_d  = 1'b1;
               auto_d  = 1'b0;
            end
         end
         ST_ACK: begin
            state_d = ST_NAK;
            addr_d  = ADDR_NAK;
         end
         ST_NAK: begin
            state_d = ST_HUNT;
            addr_d  = IDLE_ADDR;
            wait_d  = '0;
         end
         ST_HUNT: begin
            wait_d = wait_q + WAIT_W'(1);
            if (!so_s) begin
               state_d = ST_DATA;
               bit_d   = '0;
            end else if (wait_d == WAIT_W'(WAIT_MAX)) begin
               state_d     = ST_DONE;
               busy_d      = 1'b0;
               stat_d.done = 1'b1;
               stat_d.err  = ERR_TIMEOUT;
            end
         end
         ST_DATA: begin
            shift_d = {so_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            state_d        = ST_DONE;
            busy_d         = 1'b0;
            stat_d.done    = 1'b1;
            stat_d.payload = shift_q;
            if (so_s) begin
               stat_d.err = ERR_FRAMING;
            end else if (shift_q != EXPECTED) begin
               stat_d.err = ERR_PAYLOAD;
            end else begin
               stat_d.ok  = 1'b1;
            end
         end
         // Terminal: the mapper only re-unlocks after a reset.
         ST_DONE: begin
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= ST_IDLE;
         addr_q  <= IDLE_ADDR;
         busy_q  <= 1'b0;
         auto_q  <= AUTO_START;
         wait_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         stat_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         auto_q  <= auto_d;
         wait_q  <= wait_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         stat_q  <= stat_d;
      end
   end

   assign bus.ADDR         = addr_q;
   assign bus.busy         = busy_q;
   assign bus.done         = stat_q.done;
   assign bus.ok           = stat_q.ok;
   assign bus.err          = stat_q.err;
   assign bus.payload      = stat_q.payload;
   assign bus.sys_ctrl1_b7 = stat_q.ok;

endmodule

// File: tb/tb_ws_cart_unlock_rx.sv
// Bench: two receivers (SYNC_STAGES 0 and 2), each paired with a behavioural
// mapper model on shared CLK/RSTn, checked against a rule-level reference.
module tb_ws_cart_unlock_rx;
   import ws_cart_unlock_rx_pkg::*;

   localparam logic [DATA_BITS-1:0] EXP    = 16'h28A0;
   localparam int unsigned          TMO    = 8;
   localparam logic [ADDR_W-1:0]    IDLE_A = 8'h00;
   localparam int                   NI     = 2;

   logic CLK  = 1'b0;
   logic RSTn = 1'b0;
   int   cyc  = 0;
   int   vectors     = 0;
   int   miscompares = 0;
   int   t_rel       = 0;

   logic                 start_r [NI] = '{default: 1'b0};
   logic                 so_r    [NI];
   logic [ADDR_W-1:0]    addr_w  [NI];
   logic                 busy_w  [NI];
   logic                 done_w  [NI];
   logic                 ok_w    [NI];
   logic                 b7_w    [NI];
   logic [ERR_W-1:0]     err_w   [NI];
   logic [DATA_BITS-1:0] pay_w   [NI];

   logic [DATA_BITS-1:0]  m_data     = EXP;
   logic                  m_dead     = 1'b0;
   logic                  m_stop_bad = 1'b0;
   logic [ADDR_W-1:0]     prev_a [NI];
   logic [FRAME_BITS-1:0] m_sh   [NI];

   int   n5a   [NI] = '{default: 0};
   int   na5   [NI] = '{default: 0};
   int   t5a   [NI] = '{default: 0};
   int   ta5   [NI] = '{default: 0};
   int   tdone [NI] = '{default: 0};
   logic done_prev [NI] = '{default: 1'b0};

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      ws_cart_unlock_rx_if ifc ();
      ws_cart_unlock_rx #(
         .EXPECTED    (EXP),
         .TIMEOUT     (TMO),
         .SYNC_STAGES (2 * g),
         .IDLE_ADDR   (IDLE_A),
         .AUTO_START  (1'b1)
      ) dut (
         .CLK  (CLK),
         .RSTn (RSTn),
         .bus  (ifc)
      );
      assign ifc.start = start_r[g];
      assign ifc.SO    = so_r[g];
      assign addr_w[g] = ifc.ADDR;
      assign busy_w[g] = ifc.busy;
      assign done_w[g] = ifc.done;
      assign ok_w[g]   = ifc.ok;
      assign b7_w[g]   = ifc.sys_ctrl1_b7;
      assign err_w[g]  = ifc.err;
      assign pay_w[g]  = ifc.payload;
   end

   // Mapper model: after seeing 5A then A5, sends start, 16 data LSB-first, stop, idle 1.
   always @(posedge CLK or negedge RSTn) begin
      for (int i = 0; i < NI; i++) begin
         if (!RSTn) begin
            so_r[i]   <= 1'b1;
            prev_a[i] <= IDLE_A;
            m_sh[i]   <= '1;
         end else begin
            prev_a[i] <= addr_w[i];
            if (!m_dead && prev_a[i] == ADDR_ACK && addr_w[i] == ADDR_NAK) begin
               so_r[i] <= 1'b0;
               m_sh[i] <= {1'b1, m_stop_bad, m_data};
            end else begin
               so_r[i] <= m_sh[i][0];
               m_sh[i] <= {1'b1, m_sh[i][FRAME_BITS-1:1]};
            end
         end
      end
   end

   // Address-bus and done-edge monitor.
   always @(negedge CLK) begin
      for (int i = 0; i < NI; i++) begin
         if (addr_w[i] == ADDR_ACK) begin n5a[i]++; t5a[i] = cyc; end
         if (addr_w[i] == ADDR_NAK) begin na5[i]++; ta5[i] = cyc; end
         if (done_w[i] && !done_prev[i]) tdone[i] = cyc;
         done_prev[i] = done_w[i];
      end
   end

   task automatic apply_reset();
      @(negedge CLK);
      RSTn = 1'b0;
      repeat (3) @(negedge CLK);
      RSTn  = 1'b1;
      t_rel = cyc;
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      while (!(done_w[0] && done_w[1]) && k < 200) begin
         @(negedge CLK);
         k++;
      end
      vectors++;
      if (k >= 200) begin
         miscompares++;
         $display("FAIL %s done-timeout: got done=%b%b want 11", name, done_w[1], done_w[0]);
      end
      @(negedge CLK);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge CLK);
      for (int i = 0; i < NI; i++) begin
         vectors++;
         if (addr_w[i] !== IDLE_A || busy_w[i] !== 1'b0 || done_w[i] !== 1'b0 ||
             ok_w[i] !== 1'b0 || err_w[i] !== 2'b00 || pay_w[i] !== 16'h0 || b7_w[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset inst%0d: got addr=%h busy=%b done=%b ok=%b err=%b pay=%h b7=%b want all idle/zero",
                     i, addr_w[i], busy_w[i], done_w[i], ok_w[i], err_w[i], pay_w[i], b7_w[i]);
         end
      end
   endtask

   task automatic test_frame(input string name, input logic [DATA_BITS-1:0] data,
                             input logic stop_bad, input logic dead);
      int s5a [NI];
      int sa5 [NI];
      m_data     = data;
      m_stop_bad = stop_bad;
      m_dead     = dead;
      for (int i = 0; i < NI; i++) begin s5a[i] = n5a[i]; sa5[i] = na5[i]; end
      apply_reset();
      wait_done(name);
      for (int i = 0; i < NI; i++) begin
         int                   sync  = 2 * i;
         int                   lat   = dead ? 2 + int'(TMO) + sync : 1 + 1 + 1 + int'(DATA_BITS) + 1 + sync;
         logic [ERR_W-1:0]     e_err = dead ? 2'b01 : stop_bad ? 2'b10 : (data != EXP) ? 2'b11 : 2'b00;
         logic                 e_ok  = (e_err == 2'b00);
         logic [DATA_BITS-1:0] e_pay = dead ? 16'h0 : data;
         vectors++;
         if (t5a[i] !== t_rel + 1 || ta5[i] !== t5a[i] + 1) begin
            miscompares++;
            $display("FAIL %s inst%0d addr-timing: got 5A@%0d A5@%0d want 5A@%0d A5@%0d",
                     name, i, t5a[i], ta5[i], t_rel + 1, t_rel + 2);
         end
         vectors++;
         if (n5a[i] - s5a[i] !== 1 || na5[i] - sa5[i] !== 1) begin
            miscompares++;
            $display("FAIL %s inst%0d addr-count: got 5A x%0d A5 x%0d want 1 each",
                     name, i, n5a[i] - s5a[i], na5[i] - sa5[i]);
         end
         vectors++;
         if (tdone[i] - t5a[i] !== lat) begin
            miscompares++;
            $display("FAIL %s inst%0d latency: got %0d want %0d", name, i, tdone[i] - t5a[i], lat);
         end
         vectors++;
         if (err_w[i] !== e_err) begin
            miscompares++;
            $display("FAIL %s inst%0d err: got %b want %b", name, i, err_w[i], e_err);
         end
         vectors++;
         if (ok_w[i] !== e_ok || b7_w[i] !== e_ok) begin
            miscompares++;
            $display("FAIL %s inst%0d ok/b7: got %b/%b want %b", name, i, ok_w[i], b7_w[i], e_ok);
         end
         vectors++;
         if (pay_w[i] !== e_pay) begin
            miscompares++;
            $display("FAIL %s inst%0d payload: got %h want %h", name, i, pay_w[i], e_pay);
         end
         vectors++;
         if (busy_w[i] !== 1'b0 || addr_w[i] !== IDLE_A) begin
            miscompares++;
            $display("FAIL %s inst%0d idle-after-done: got busy=%b addr=%h want 0/%h",
                     name, i, busy_w[i], addr_w[i], IDLE_A);
         end
      end
   endtask

   task automatic test_start_ignored();
      int s5a [NI];
      m_data = EXP; m_stop_bad = 1'b0; m_dead = 1'b0;
      for (int i = 0; i < NI; i++) s5a[i] = n5a[i];
      apply_reset();
      repeat (8) @(negedge CLK);
      start_r = '{default: 1'b1};
      @(negedge CLK);
      start_r = '{default: 1'b0};
      wait_done("start_in_data");
      start_r = '{default: 1'b1};
      @(negedge CLK);
      start_r = '{default: 1'b0};
      repeat (30) @(negedge CLK);
      for (int i = 0; i < NI; i++) begin
         vectors++;
         if (n5a[i] - s5a[i] !== 1) begin
            miscompares++;
            $display("FAIL start_ignored inst%0d reissue: got 5A x%0d want 1", i, n5a[i] - s5a[i]);
         end
         vectors++;
         if (done_w[i] !== 1'b1 || ok_w[i] !== 1'b1 || err_w[i] !== 2'b00 ||
             pay_w[i] !== EXP || busy_w[i] !== 1'b0 || addr_w[i] !== IDLE_A) begin
            miscompares++;
            $display("FAIL start_ignored inst%0d outputs: got done=%b ok=%b err=%b pay=%h busy=%b addr=%h want 1/1/00/%h/0/%h",
                     i, done_w[i], ok_w[i], err_w[i], pay_w[i], busy_w[i], addr_w[i], EXP, IDLE_A);
         end
      end
   endtask

   task automatic test_reset_mid();
      int s5a [NI];
      m_data = EXP; m_stop_bad = 1'b0; m_dead = 1'b0;
      apply_reset();
      repeat (11) @(negedge CLK);
      vectors++;
      if (busy_w[0] !== 1'b1 || busy_w[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid pre-busy: got %b%b want 11", busy_w[1], busy_w[0]);
      end
      RSTn = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         vectors++;
         if (addr_w[i] !== IDLE_A || busy_w[i] !== 1'b0 || done_w[i] !== 1'b0 ||
             ok_w[i] !== 1'b0 || err_w[i] !== 2'b00 || pay_w[i] !== 16'h0 || b7_w[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid async inst%0d: got addr=%h busy=%b done=%b ok=%b err=%b pay=%h b7=%b want idle/zero",
                     i, addr_w[i], busy_w[i], done_w[i], ok_w[i], err_w[i], pay_w[i], b7_w[i]);
         end
         s5a[i] = n5a[i];
      end
      apply_reset();
      wait_done("reset_mid");
      for (int i = 0; i < NI; i++) begin
         vectors++;
         if (ok_w[i] !== 1'b1 || err_w[i] !== 2'b00 || pay_w[i] !== EXP || n5a[i] - s5a[i] !== 1) begin
            miscompares++;
            $display("FAIL reset_mid rerun inst%0d: got ok=%b err=%b pay=%h 5A x%0d want 1/00/%h/1",
                     i, ok_w[i], err_w[i], pay_w[i], n5a[i] - s5a[i], EXP);
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame("nominal", EXP, 1'b0, 1'b0);
      test_frame("dead_cart", EXP, 1'b0, 1'b1);
      test_frame("stop_bad", EXP, 1'b1, 1'b0);
      test_frame("mismatch", 16'h28A1, 1'b0, 1'b0);
      for (int r = 0; r < 6; r++) begin
         logic [DATA_BITS-1:0] d  = ($urandom_range(0, 3) == 0) ? EXP : 16'($urandom);
         logic                 sb = ($urandom_range(0, 3) == 0);
         test_frame("random", d, sb, 1'b0);
      end
      test_start_ignored();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
